// File: rtl/pd_pkg.sv
// Shared types and constants for the peak detection pipeline stages.
package pd_pkg;

    localparam int PD_DATAWIDTH = 16;

    typedef enum logic [1:0] {
        PC_IDLE    = 2'd0,
        PC_COLLECT = 2'd1,
        PC_FLUSH   = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pd_peak_fifo.sv
// Synchronous FIFO with a separate occupancy counter and a zero-latency head.
module pd_peak_fifo #(
    parameter int DEPTH     = 8,
    parameter int DATAWIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clr,
    input  logic [DATAWIDTH-1:0]         wdata,
    output logic [DATAWIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero when empty so the output is clean out of reset.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/peak_collector.sv
// Frame-bracketed collector: buffers detector peaks in a FIFO, counts them and
// flags drops; rd_valid/rd_ready transfer a word on any edge where both are high.
module peak_collector
    import pd_pkg::*;
#(
    parameter int DATAWIDTH = PD_DATAWIDTH,
    parameter int DEPTH     = 8,
    parameter int CNTW      = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start_act,
    input  logic                   frame_end,
    input  logic                   peak_valid,
    input  logic [DATAWIDTH-1:0]   peak_info,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [DATAWIDTH-1:0]   rd_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNTW-1:0]        peak_count,
    output logic                   overflow,
    output logic                   frame_done,
    output logic                   busy,
    output pc_state_t              fsm_state
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    pc_state_t              state;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] level;

    assign pop        = !empty && rd_ready;
    assign push       = peak_valid && (state == PC_COLLECT) && (!full || pop);
    assign drop       = peak_valid && (state == PC_COLLECT) && !push;
    assign rd_valid   = !empty;
    assign fifo_level = level;
    assign fsm_state  = state;

    pd_peak_fifo #(
        .DEPTH     (DEPTH),
        .DATAWIDTH (DATAWIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .clr     (start_act),
        .wdata   (peak_info),
        .rdata   (rd_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    // start_act overrides everything, including a frame_end or a pending done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PC_IDLE;
            peak_count <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start_act) begin
                state      <= PC_COLLECT;
                busy       <= 1'b1;
                peak_count <= '0;
                overflow   <= 1'b0;
            end else begin
                if (push && (peak_count != CNT_MAX)) begin
                    peak_count <= peak_count + CNT_ONE;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
                case (state)
                    PC_IDLE: begin
                        busy <= 1'b0;
                    end
                    PC_COLLECT: begin
                        if (frame_end) begin
                            state <= PC_FLUSH;
                        end
                    end
                    PC_FLUSH: begin
                        if (empty) begin
                            state      <= PC_IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                    default: begin
                        state <= PC_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_peak_collector.sv
// Scoreboard bench for peak_collector: a cycle model tracks the expected FIFO
// contents, counters and frame state; outputs are compared every cycle.
module tb_peak_collector;
    import pd_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_act = 1'b0;
    logic          frame_end = 1'b0;
    logic          peak_valid = 1'b0;
    logic [DW-1:0] peak_info = '0;
    logic          rd_ready = 1'b0;

    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [LW-1:0] fifo_level;
    logic [7:0]    peak_count;
    logic          overflow;
    logic          frame_done;
    logic          busy;
    pc_state_t     fsm_state;

    logic          rd_valid4;
    logic [DW-1:0] rd_data4;
    logic [LW-1:0] fifo_level4;
    logic [3:0]    peak_count4;
    logic          overflow4;
    logic          frame_done4;
    logic          busy4;
    pc_state_t     fsm_state4;

    peak_collector #(.DATAWIDTH(DW), .DEPTH(DEPTH), .CNTW(8)) dut (
        .clk(clk), .reset_n(reset_n), .start_act(start_act), .frame_end(frame_end),
        .peak_valid(peak_valid), .peak_info(peak_info), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .fifo_level(fifo_level),
        .peak_count(peak_count), .overflow(overflow), .frame_done(frame_done),
        .busy(busy), .fsm_state(fsm_state)
    );

    peak_collector #(.DATAWIDTH(DW), .DEPTH(DEPTH), .CNTW(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start_act(start_act), .frame_end(frame_end),
        .peak_valid(peak_valid), .peak_info(peak_info), .rd_ready(rd_ready),
        .rd_valid(rd_valid4), .rd_data(rd_data4), .fifo_level(fifo_level4),
        .peak_count(peak_count4), .overflow(overflow4), .frame_done(frame_done4),
        .busy(busy4), .fsm_state(fsm_state4)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];
    pc_state_t     m_state = PC_IDLE;
    int            m_count = 0;
    int            m_count4 = 0;
    logic          m_ovf = 1'b0;
    logic          m_done = 1'b0;
    bit            chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_peak(input logic [DW-1:0] d);
        peak_valid = 1'b1;
        peak_info  = d;
        tick(1);
        peak_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start_act = 1'b1;
        tick(1);
        start_act = 1'b0;
    endtask

    task automatic pulse_end();
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("frame_done_timeout", seen, 1);
        check_eq("busy_with_done", busy, 0);
    endtask

    // Reference model advanced once per cycle from the inputs in effect at the next edge.
    task automatic model_step();
        bit pop_m;
        bit push_m;
        int size_before;
        size_before = exp_q.size();
        pop_m = (size_before != 0) && rd_ready;
        m_done = 1'b0;
        if (start_act) begin
            exp_q.delete();
            m_count  = 0;
            m_count4 = 0;
            m_ovf    = 1'b0;
            m_state  = PC_COLLECT;
        end else begin
            push_m = peak_valid && (m_state == PC_COLLECT) && ((size_before < DEPTH) || pop_m);
            if (pop_m) void'(exp_q.pop_front());
            if (push_m) begin
                exp_q.push_back(peak_info);
                if (m_count < 255) m_count++;
                if (m_count4 < 15) m_count4++;
            end
            if (peak_valid && (m_state == PC_COLLECT) && !push_m) m_ovf = 1'b1;
            case (m_state)
                PC_COLLECT: if (frame_end) m_state = PC_FLUSH;
                PC_FLUSH: if (size_before == 0) begin
                    m_state = PC_IDLE;
                    m_done  = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                m_state  = PC_IDLE;
                m_count  = 0;
                m_count4 = 0;
                m_ovf    = 1'b0;
                m_done   = 1'b0;
            end else if (chk_en) begin
                check_eq("rd_valid", rd_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    check_eq("rd_data", rd_data, exp_q[0]);
                    check_eq("rd_data4", rd_data4, exp_q[0]);
                end
                check_eq("fifo_level", fifo_level, exp_q.size());
                check_eq("peak_count", peak_count, m_count);
                check_eq("peak_count4", peak_count4, m_count4);
                check_eq("overflow", overflow, m_ovf);
                check_eq("frame_done", frame_done, m_done);
                check_eq("busy", busy, m_state != PC_IDLE);
                check_eq("state", fsm_state, m_state);
                model_step();
            end
        end
    end

    initial begin
        tick(2);
        check_eq("rst_state", fsm_state, PC_IDLE);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_busy", busy, 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick(1);

        // Reset mid-frame
        pulse_start();
        for (int i = 0; i < 3; i++) send_peak(DW'(16'h0a00 + i));
        check_eq("pre_rst_level", fifo_level, 3);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_rd_valid", rd_valid, 0);
        check_eq("arst_rd_data", rd_data, 0);
        check_eq("arst_level", fifo_level, 0);
        check_eq("arst_count", peak_count, 0);
        check_eq("arst_overflow", overflow, 0);
        check_eq("arst_frame_done", frame_done, 0);
        check_eq("arst_busy", busy, 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check_eq("post_rst_state", fsm_state, PC_IDLE);
        check_eq("post_rst_level", fifo_level, 0);

        // Basic frame, plus gating of peaks in FLUSH and IDLE
        pulse_start();
        for (int i = 1; i <= 5; i++) send_peak(DW'(16'h0100 + i));
        check_eq("basic_level", fifo_level, 5);
        check_eq("basic_count", peak_count, 5);
        check_eq("basic_head", rd_data, 16'h0101);
        pulse_end();
        send_peak(16'hdead);
        check_eq("flush_gate_count", peak_count, 5);
        check_eq("flush_gate_level", fifo_level, 5);
        rd_ready = 1'b1;
        wait_done(30);
        rd_ready = 1'b0;
        send_peak(16'hbeef);
        check_eq("idle_gate_count", peak_count, 5);
        check_eq("idle_gate_level", fifo_level, 0);

        // Overflow
        pulse_start();
        for (int i = 0; i < 10; i++) send_peak(DW'(16'h0200 + i));
        check_eq("ovf_level", fifo_level, 8);
        check_eq("ovf_count", peak_count, 8);
        check_eq("ovf_flag", overflow, 1);
        pulse_start();
        check_eq("ovf_clr_flag", overflow, 0);
        check_eq("ovf_clr_count", peak_count, 0);

        // Full with simultaneous pop
        for (int i = 0; i < 8; i++) send_peak(DW'(16'h0300 + i));
        rd_ready = 1'b1;
        send_peak(16'h0388);
        rd_ready = 1'b0;
        check_eq("fullpop_level", fifo_level, 8);
        check_eq("fullpop_ovf", overflow, 0);
        check_eq("fullpop_count", peak_count, 9);

        // start_act and frame_end together in COLLECT
        start_act = 1'b1;
        frame_end = 1'b1;
        tick(1);
        start_act = 1'b0;
        frame_end = 1'b0;
        check_eq("startend_state", fsm_state, PC_COLLECT);
        check_eq("startend_level", fifo_level, 0);
        tick(2);
        check_eq("startend_nodone", frame_done, 0);

        // Wrap and saturation, streaming with random data
        rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) send_peak(DW'($urandom_range(0, 16'hffff)));
        check_eq("sat_count4", peak_count4, 15);
        check_eq("sat_count8", peak_count, 20);
        pulse_end();
        wait_done(30);
        rd_ready = 1'b0;

        tick(3);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/peak_collector.md
Name: peak_collector

Overview:
- Downstream of the peak detector; consumes its peak_valid/peak_info stream.
- Buffers accepted peaks in a small FIFO for a consumer such as a register-readout or DMA port, using a valid/ready interface.
- Counts peaks per frame and flags overflow.
- A frame FSM brackets collection between start_act and frame_end, then drains and signals done.

Parameters:
- DATAWIDTH, 16, width of peak_info and rd_data.
- DEPTH, 8, FIFO entries; power of two, >=2.
- CNTW, 8, width of peak_count; saturating.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start_act  input  1  frame start pulse; clears FIFO, counters and flags; enters COLLECT.
- frame_end  input  1  end-of-frame pulse; enters FLUSH.
- peak_valid  input  1  peak present on peak_info this cycle.
- peak_info  input  DATAWIDTH  peak descriptor from the detector.
- rd_ready  input  1  consumer accepts rd_data.
- rd_valid  output  1  FIFO non-empty.
- rd_data  output  DATAWIDTH  FIFO head entry.
- fifo_level  output  $clog2(DEPTH)+1  current occupancy.
- peak_count  output  CNTW  peaks accepted this frame; saturates at 2^CNTW-1.
- overflow  output  1  sticky; a peak was dropped this frame.
- frame_done  output  1  one-cycle pulse when FLUSH completes.
- busy  output  1  high in COLLECT or FLUSH.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State is IDLE.
  - Pointers, fifo_level, peak_count and overflow are 0.
  - rd_valid, frame_done and busy are 0.
  - rd_data is 0.
- FSM states are IDLE, COLLECT and FLUSH.
  - IDLE: on start_act, go to COLLECT.
  - COLLECT: on frame_end, go to FLUSH.
  - FLUSH: when fifo_level==0, go to IDLE and pulse frame_done in the same cycle as the transition.
  - start_act in any state: synchronous clear of FIFO, peak_count and overflow; next state COLLECT. A frame_done pending that cycle is suppressed.
  - start_act and frame_end in the same cycle: start_act wins; frame_end is ignored.
- Write:
  - push = peak_valid && state==COLLECT && (fifo_level<DEPTH || pop).
  - peak_valid in IDLE or FLUSH is ignored; it sets no flag and no count.
  - peak_valid in COLLECT while full and no pop: the entry is dropped, overflow is set (sticky until start_act) and peak_count is unchanged.
  - Each accepted push increments peak_count by 1, saturating.
- Read:
  - rd_valid = (fifo_level!=0). rd_data = mem[rd_ptr], combinational from registered storage.
  - Zero-latency head: a word pushed at edge N is visible on rd_data after edge N.
  - pop = rd_valid && rd_ready. rd_data must hold stable while rd_valid && !rd_ready.
  - rd_data is don't-care when rd_valid==0; the bench must not check it then.
  - Reads are allowed in every state, including IDLE after frame_done (the FIFO is empty then).
- Simultaneous push and pop: fifo_level is unchanged; both pointers advance.
  - Applies at full: the push is accepted because a slot frees this cycle.
  - Applies at empty: no push+pop is possible because rd_valid==0.
- Pointers: log2(DEPTH)-bit, wrap modulo DEPTH. fifo_level is a separate up/down counter (0..DEPTH).
- start_act clearing the FIFO: pointers and level go to 0 at the next edge. A pop in the same cycle has no further effect.
- busy = (state!=IDLE), registered from state.

Decomposition:
- Shared package pd_pkg:
  - state enum pc_state_t {PC_IDLE, PC_COLLECT, PC_FLUSH}.
  - DATAWIDTH default constant, shared with the detector and filter stages.
- Sub-module pd_peak_fifo: synchronous FIFO (DEPTH, DATAWIDTH).
  - Inputs: push, pop, clr, wdata.
  - Outputs: rdata, level, full, empty.
- peak_collector instantiates pd_peak_fifo and holds the FSM, counter and overflow logic.

Test Plan:
- Reset mid-frame:
  - Stimulus: after 3 pushes, assert reset_n=0 asynchronously.
  - Required: all outputs are 0 immediately, and after release state is IDLE with fifo_level=0.
- Basic frame (DEPTH=8):
  - Stimulus: start_act; 5 peaks 0x0101..0x0105 with rd_ready=0; frame_end; then rd_ready=1.
  - Required: fifo_level=5 and peak_count=5; rd_data reads 0x0101..0x0105 in order; frame_done pulses once, the cycle after the last pop; busy falls with it.
- Overflow:
  - Stimulus: rd_ready=0 and 10 consecutive peaks.
  - Required: first 8 stored, peak_count=8, overflow=1 from the 9th peak, fifo_level=8.
  - Follow-up: the next start_act clears overflow and peak_count.
- Full with simultaneous pop:
  - Stimulus: FIFO at 8 entries; peak_valid and rd_ready in the same cycle.
  - Required: push accepted, fifo_level stays 8, overflow stays 0, peak_count increments.
- Gating:
  - Stimulus: peak_valid in IDLE and in FLUSH.
  - Required: no push, peak_count unchanged.
  - Stimulus: start_act and frame_end in the same cycle during COLLECT.
  - Required: FIFO cleared, state COLLECT, no frame_done.
- Wrap and saturation:
  - Stimulus: CNTW=4, 20 peaks streamed with rd_ready=1.
  - Required: data order preserved across pointer wrap; peak_count saturates at 15.
